// File: rtl/ddr2_64bit_ex_rdata_checker_if.sv
// rtl/ddr2_64bit_ex_rdata_checker_if.sv - read-data checker control/status bundle
// Master drives start and read data; slave (the checker) returns test status.
interface ddr2_64bit_ex_rdata_checker_if;
  logic        start;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        test_complete;
  logic [7:0]  pnf_per_byte;
  logic        pnf;
  logic [15:0] err_count;

  modport master (
    output start, rdata, rdata_valid,
    input  busy, test_complete, pnf_per_byte, pnf, err_count
  );

  modport slave (
    input  start, rdata, rdata_valid,
    output busy, test_complete, pnf_per_byte, pnf, err_count
  );
endinterface

// File: rtl/ddr2_64bit_ex_rdata_checker.sv
// rtl/ddr2_64bit_ex_rdata_checker.sv - per-lane LFSR read-data checker for a 64-bit DDR2 path
// Optional error-beat counter enabled by macro DDR2_EX_ERR_CNT_EN.
module ddr2_64bit_ex_rdata_checker #(
  parameter int unsigned SEED_BASE = 32,
  parameter int unsigned NUM_BEATS = 64
) (
  input logic                          clk,
  input logic                          reset_n,
  ddr2_64bit_ex_rdata_checker_if.slave chk
);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;

  localparam logic [15:0] LAST_BEAT = 16'(NUM_BEATS - 1);

  state_e          state_q, state_d;
  logic [7:0][7:0] gen_q, gen_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]      pnf_q, pnf_d;
  logic [7:0]      lane_fail;
  logic            beat_acc;
  logic            start_load;

  function automatic logic [7:0][7:0] lane_seeds();
    logic [7:0][7:0] s;
    for (int i = 0; i < 8; i++) begin
      s[i] = 8'((SEED_BASE + 32'(i)) % 256);
    end
    return s;
  endfunction

  function automatic logic [7:0] gen_step(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane_fail[i] = (chk.rdata[8*i +: 8] != gen_q[i]);
    end
  end

  // start is only honoured outside CHECK; rdata_valid only inside it
  assign start_load = (state_q != CHECK) && chk.start;
  assign beat_acc   = (state_q == CHECK) && chk.rdata_valid;

  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    beat_cnt_d = beat_cnt_q;
    pnf_d      = pnf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_load) begin
          state_d    = CHECK;
          gen_d      = lane_seeds();
          beat_cnt_d = '0;
          pnf_d      = 8'hFF;
        end
      end
      CHECK: begin
        if (beat_acc) begin
          pnf_d      = pnf_q & ~lane_fail;
          beat_cnt_d = beat_cnt_q + 16'd1;
          for (int i = 0; i < 8; i++) begin
            gen_d[i] = gen_step(gen_q[i]);
          end
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gen_q      <= lane_seeds();
      beat_cnt_q <= '0;
      pnf_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      beat_cnt_q <= beat_cnt_d;
      pnf_q      <= pnf_d;
    end
  end

`ifdef DDR2_EX_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start_load) begin
      err_d = '0;
    end else if (beat_acc && (|lane_fail) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign chk.err_count = err_q;
`else
  assign chk.err_count = 16'h0000;
`endif

  assign chk.busy          = (state_q == CHECK);
  assign chk.test_complete = (state_q == DONE);
  assign chk.pnf_per_byte  = pnf_q;
  assign chk.pnf           = &pnf_q;
endmodule
